// File: rtl/riscv_core_pkg.sv
// Shared types for the execute-stage divider: operation codes, FSM states
// and small decode helpers.
package riscv_core_pkg;

  localparam int DIV_OP_W = 2;

  typedef enum logic [DIV_OP_W-1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // True for the two-operand-signed operations (DIV, REM).
  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  // True when the operation returns the remainder instead of the quotient.
  function automatic logic op_is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/radix_div_unit_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference only when it
// does not borrow. The new quotient bit enters at the LSB.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted_s;
  logic [XLEN-1:0] diff_s;

  // Shift-subtract-select for a single quotient bit.
  always_comb begin
    shifted_s = {rem_i, quo_i[XLEN-1]};
    // The partial remainder stays below the divisor, so the difference fits in XLEN bits.
    diff_s    = shifted_s[XLEN-1:0] - divisor_i;
    if (shifted_s >= {1'b0, divisor_i}) begin
      rem_o = diff_s;
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/radix_div_unit.sv
// Iterative radix-2^BITS_PER_CYCLE integer divider with valid/ready handshakes,
// tag passthrough, flush, and single-cycle handling of the RISC-V divide-by-zero
// and signed-overflow cases.
module radix_div_unit
  import riscv_core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DIV_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]     operand_a_i,
  input  logic [XLEN-1:0]     operand_b_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     result_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic                div_by_zero_o,
  output logic                busy_o
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             dbz_q, dbz_d;

  // Request decode, computed straight from the input operands.
  div_op_e         op_in_s;
  logic            in_signed_s, a_neg_s, b_neg_s, ovf_s, accept_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s, quo_fix_s, rem_fix_s;

  assign op_in_s     = div_op_e'(op_i);
  assign in_signed_s = op_is_signed(op_in_s);
  assign a_neg_s     = in_signed_s & operand_a_i[XLEN-1];
  assign b_neg_s     = in_signed_s & operand_b_i[XLEN-1];
  assign a_mag_s     = a_neg_s ? -operand_a_i : operand_a_i;
  assign b_mag_s     = b_neg_s ? -operand_b_i : operand_b_i;
  assign ovf_s       = in_signed_s && (operand_a_i == INT_MIN) && (operand_b_i == ALL_ONES);

  assign in_ready_o = !flush_i && ((state_q == IDLE) || ((state_q == DONE) && out_ready_i));
  assign accept_s   = in_valid_i && in_ready_o;

  // Chain of combinational steps retiring BITS_PER_CYCLE quotient bits per clock.
  logic [XLEN-1:0] rem_chain_s [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] quo_chain_s [BITS_PER_CYCLE+1];

  assign rem_chain_s[0] = rem_q;
  assign quo_chain_s[0] = quo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_i     (rem_chain_s[g]),
      .quo_i     (quo_chain_s[g]),
      .divisor_i (dvs_q),
      .rem_o     (rem_chain_s[g+1]),
      .quo_o     (quo_chain_s[g+1])
    );
  end

  // Sign fix-up applied to the final step's outputs.
  assign quo_fix_s = neg_quo_q ? -quo_chain_s[BITS_PER_CYCLE] : quo_chain_s[BITS_PER_CYCLE];
  assign rem_fix_s = neg_rem_q ? -rem_chain_s[BITS_PER_CYCLE] : rem_chain_s[BITS_PER_CYCLE];

  // Next-state and datapath update: flush, then accept, then per-state work.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    if (flush_i) begin
      state_d = IDLE;
    end else if (accept_s) begin
      op_d      = op_in_s;
      tag_d     = tag_i;
      rem_d     = {XLEN{1'b0}};
      quo_d     = a_mag_s;
      dvs_d     = b_mag_s;
      neg_quo_d = a_neg_s ^ b_neg_s;
      neg_rem_d = a_neg_s;
      cnt_d     = CNT_W'(STEPS - 1);
      if (operand_b_i == {XLEN{1'b0}}) begin
        state_d  = DONE;
        result_d = op_is_rem(op_in_s) ? operand_a_i : ALL_ONES;
        dbz_d    = 1'b1;
      end else if (ovf_s) begin
        state_d  = DONE;
        result_d = op_is_rem(op_in_s) ? {XLEN{1'b0}} : INT_MIN;
        dbz_d    = 1'b0;
      end else begin
        state_d  = CALC;
        dbz_d    = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        CALC: begin
          rem_d = rem_chain_s[BITS_PER_CYCLE];
          quo_d = quo_chain_s[BITS_PER_CYCLE];
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d  = DONE;
            result_d = op_is_rem(op_q) ? rem_fix_s : quo_fix_s;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= DIV;
      tag_q     <= {TAG_W{1'b0}};
      rem_q     <= {XLEN{1'b0}};
      quo_q     <= {XLEN{1'b0}};
      dvs_q     <= {XLEN{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      result_q  <= {XLEN{1'b0}};
      dbz_q     <= 1'b0;
    end else begin
      op_q      <= op_d;
      tag_q     <= tag_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
    end
  end

  assign out_valid_o   = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);
  assign result_o      = result_q;
  assign tag_o         = tag_q;
  assign div_by_zero_o = dbz_q;

endmodule
